// File: rtl/stream_drain_ctrl.sv
// Drains a byte stream buffer into 32-bit MSB-first words behind a small output FIFO.
// Define DRAIN_LEN_HEADER_EN to prepend a {16'hD1CE, byte_count} header word to each stream.
module stream_drain_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] byte_count,
  output logic        busy,
  output logic        done,
  output logic        sb_read_en,
  input  logic [7:0]  sb_byte,
  input  logic        sb_valid,
  output logic [31:0] m_data,
  output logic [3:0]  m_keep,
  output logic        m_last,
  output logic        m_valid,
  input  logic        m_ready
);

  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int CREDIT = 4 * FIFO_DEPTH;
  localparam int IF_W   = $clog2(CREDIT + RD_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, DONE} state_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } fifo_word_t;

  state_t            state_reg, state_next;
  logic [15:0]       count_reg, issued_reg;
  logic [IF_W-1:0]   in_flight_reg;
  logic [31:0]       pack_reg;
  logic [1:0]        fill_reg;
  logic [PW-1:0]     wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [PW:0]       used_reg, used_after_pop;
  fifo_word_t        mem [FIFO_DEPTH];
  fifo_word_t        out_reg, push_word;
  logic              push, pop, byte_ok, start_ok;
  logic [17:0]       credit_sum;

  // Bytes arriving with nothing outstanding are stale (e.g. from before a reset).
  assign byte_ok    = sb_valid && (in_flight_reg != '0);
  assign pop        = m_valid && m_ready;
  assign credit_sum = 18'(in_flight_reg) + 18'(fill_reg) + 18'({used_reg, 2'b00});
  assign sb_read_en = (state_reg == DRAIN) && (issued_reg < count_reg) &&
                      (credit_sum < 18'(CREDIT));
  assign busy       = (state_reg != IDLE);

  always_comb begin
    state_next = state_reg;
    start_ok   = 1'b0;
    push       = 1'b0;
    push_word  = '0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          start_ok   = 1'b1;
          state_next = (byte_count == 16'd0) ? FLUSH : DRAIN;
`ifdef DRAIN_LEN_HEADER_EN
          push       = 1'b1;
          push_word  = '{data: {16'hD1CE, byte_count}, keep: 4'b1111,
                         last: (byte_count == 16'd0)};
`endif
        end
      end
      DRAIN: begin
        if (issued_reg == count_reg) state_next = FLUSH;
      end
      FLUSH: begin
        if (in_flight_reg == '0) begin
          if (fill_reg != 2'd0) begin
            push      = 1'b1;
            push_word = '{data: pack_reg, keep: ~(4'b1111 >> fill_reg), last: 1'b1};
          end
          state_next = DONE;
        end
      end
      DONE: begin
        if (used_reg == '0) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // A completed word is last when it holds the final outstanding byte of the stream.
    if (byte_ok && fill_reg == 2'd3) begin
      push      = 1'b1;
      push_word = '{data: {pack_reg[31:8], sb_byte}, keep: 4'b1111,
                    last: (issued_reg == count_reg) && (in_flight_reg == IF_W'(1))};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      issued_reg    <= '0;
      in_flight_reg <= '0;
      pack_reg      <= '0;
      fill_reg      <= '0;
    end else begin
      state_reg <= state_next;
      if (start_ok) begin
        count_reg     <= byte_count;
        issued_reg    <= '0;
        in_flight_reg <= '0;
        pack_reg      <= '0;
        fill_reg      <= '0;
      end else begin
        if (sb_read_en) issued_reg <= issued_reg + 16'd1;
        in_flight_reg <= in_flight_reg + IF_W'(sb_read_en) - IF_W'(byte_ok);
        if (byte_ok) begin
          if (fill_reg == 2'd3) begin
            pack_reg <= '0;
            fill_reg <= 2'd0;
          end else begin
            pack_reg <= pack_reg | (32'(sb_byte) << {2'd3 - fill_reg, 3'b000});
            fill_reg <= fill_reg + 2'd1;
          end
        end
      end
    end
  end

  assign rd_ptr_next    = rd_ptr_reg + PW'(pop);
  assign used_after_pop = used_reg - (PW+1)'(pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= push_word;
  end

  // Head of the FIFO lives in out_reg; a push into an empty (or draining-to-empty) FIFO bypasses mem.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      used_reg   <= '0;
      out_reg    <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + PW'(push);
      rd_ptr_reg <= rd_ptr_next;
      used_reg   <= used_after_pop + (PW+1)'(push);
      if (push && used_after_pop == '0) out_reg <= push_word;
      else if (used_after_pop != '0)    out_reg <= mem[rd_ptr_next];
      else                              out_reg <= '0;
    end
  end

  assign m_valid = (used_reg != '0);
  assign m_data  = out_reg.data;
  assign m_keep  = out_reg.keep;
  assign m_last  = out_reg.last;

endmodule

// File: doc/stream_drain_ctrl.md
STREAM_DRAIN_CTRL -- requirements
Module: stream_drain_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, output word FIFO depth in 32-bit words (power of two, >=2).
REQ-002 Parameter RD_LATENCY, default 2, cycles from sb_read_en high to matching sb_valid.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse; begin draining an encoded stream.
REQ-006 byte_count  input  16  stream length in bytes, sampled on accepted start.
REQ-007 busy  output  1  high from accepted start until done pulse.
REQ-008 done  output  1  one-cycle pulse after final word accepted downstream.
REQ-009 sb_read_en  output  1  byte read request to stream buffer.
REQ-010 sb_byte  input  8  byte returned by stream buffer.
REQ-011 sb_valid  input  1  sb_byte valid.
REQ-012 m_data  output  32  packed output word; first byte of stream in [31:24].
REQ-013 m_keep  output  4  byte enables; bit 3 = [31:24].
REQ-014 m_last  output  1  marks final word of stream.
REQ-015 m_valid / m_ready  output / input  1 / 1  ready-valid handshake; transfer when both high.

Function
REQ-016 States: IDLE, DRAIN, FLUSH, DONE.
REQ-017 IDLE: start accepted -> latch byte_count, clear counters, enter DRAIN; start while busy is ignored.
REQ-018 DRAIN: assert sb_read_en only when issued < latched count AND in_flight + pack_fill + 4*fifo_used < 4*FIFO_DEPTH; in_flight = requests issued not yet returned.
REQ-019 DRAIN -> FLUSH when issued == latched count.
REQ-020 Returned bytes pack MSB-first into a 32-bit pack register; fourth byte pushes word with m_keep=4'b1111 into FIFO same cycle, no bubble.
REQ-021 FLUSH: when all bytes returned, push any partial word zero-padded, m_keep = leading ones per byte held (1->1000, 2->1100, 3->1110), then enter DONE.
REQ-022 The final pushed word carries m_last=1; all others m_last=0.
REQ-023 DONE: wait until FIFO empty and last word transferred, pulse done, return to IDLE.
REQ-024 byte_count == 0: no sb_read_en, no data word (header aside, REQ-033), done pulses 2 cycles after start.
REQ-025 FIFO outputs m_data/m_keep/m_last registered; m_valid high while FIFO non-empty; m_data held stable while m_valid && !m_ready.
REQ-026 FIFO push and pop in the same cycle keep occupancy unchanged; credit rule of REQ-018 guarantees no overflow.
REQ-027 sb_valid with in_flight == 0 is ignored, no state change.
REQ-028 Counters 16-bit; no wrap possible since issued <= byte_count <= 65535.
REQ-029 Sustained throughput with m_ready held high: one byte per cycle after RD_LATENCY startup.

Reset
REQ-030 rst_n low asynchronously clears: state IDLE, counters, pack register, FIFO pointers; outputs busy=0, done=0, sb_read_en=0, m_valid=0, m_last=0, m_keep=0, m_data=0.
REQ-031 Reset mid-drain abandons stream; in-flight sb_valid bytes arriving after release are ignored per REQ-027.
REQ-032 Outputs leave reset values only on the first clk edge after rst_n deasserts.

Configuration
REQ-033 Macro DRAIN_LEN_HEADER_EN defined: one header word {16'hD1CE, byte_count} with m_keep=4'b1111 pushed before first data word; m_last on header only if byte_count==0.
REQ-034 DRAIN_LEN_HEADER_EN undefined: no header; stream begins with first data word.
REQ-035 Header word occupies one FIFO slot and counts in the REQ-018 credit check.

Verification
REQ-036 byte_count=8, bytes 01..08, m_ready=1 -> words 01020304 (keep F), 05060708 (keep F, last), done; 8 sb_read_en cycles.
REQ-037 byte_count=5 -> second word 05000000, keep 1000, last=1.
REQ-038 byte_count=64, m_ready low 40 cycles -> sb_read_en stalls, never >16 bytes buffered, all 16 words in order, none lost.
REQ-039 byte_count=0 -> no sb_read_en, done 2 cycles after start; with header, single word D1CE0000 last=1.
REQ-040 rst_n low mid-stream at byte 10 of 32 -> all outputs reset immediately; new start with byte_count=4 drains cleanly.
